// File: rtl/pipe_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// drives the IF/ID register, honouring stall from hazards and redirect from EX.
module pipe_fetch_stage #(
  parameter int               XLEN      = 64,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [31:0]     fetch_count
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]      state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            discard_reg, discard_next;
  logic [XLEN-1:0] buf_pc_reg, buf_pc_next;
  logic [31:0]     buf_instr_reg, buf_instr_next;
  logic            id_valid_reg, id_valid_next;
  logic [XLEN-1:0] id_pc_reg, id_pc_next;
  logic [31:0]     id_instr_reg, id_instr_next;
  logic [31:0]     count_reg, count_next;

  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redirect_target;
  logic            unused_redirect_bits;

  assign pc_inc               = pc_reg + XLEN'(4);
  assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Request is suppressed while reset is asserted even though state is REQ.
  assign imem_req    = rst && (state_reg == ST_REQ);
  assign imem_addr   = pc_reg;
  assign id_valid    = id_valid_reg;
  assign id_pc       = id_pc_reg;
  assign id_instr    = id_instr_reg;
  assign fetch_count = count_reg;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    discard_next   = discard_reg;
    buf_pc_next    = buf_pc_reg;
    buf_instr_next = buf_instr_reg;
    id_valid_next  = id_valid_reg;
    id_pc_next     = id_pc_reg;
    id_instr_next  = id_instr_reg;
    count_next     = count_reg;

    // Without stall, IF/ID becomes a bubble unless something is delivered below.
    if (!stall) begin
      id_valid_next = 1'b0;
      id_instr_next = NOP_INSTR;
    end

    case (state_reg)
      ST_REQ: begin
        if (imem_ready) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (discard_reg) begin
            discard_next = 1'b0;
            state_next   = ST_REQ;
          end else if (!stall) begin
            id_valid_next = 1'b1;
            id_pc_next    = pc_reg;
            id_instr_next = imem_rdata;
            pc_next       = pc_inc;
            count_next    = count_reg + 32'd1;
            state_next    = ST_REQ;
          end else begin
            buf_pc_next    = pc_reg;
            buf_instr_next = imem_rdata;
            state_next     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          id_valid_next = 1'b1;
          id_pc_next    = buf_pc_reg;
          id_instr_next = buf_instr_reg;
          pc_next       = pc_inc;
          count_next    = count_reg + 32'd1;
          state_next    = ST_REQ;
        end
      end
      default: begin
        state_next = ST_REQ;
      end
    endcase

    // Redirect overrides everything above, including stall and any delivery.
    if (redirect_valid) begin
      id_valid_next = 1'b0;
      id_pc_next    = id_pc_reg;
      id_instr_next = NOP_INSTR;
      pc_next       = redirect_target;
      count_next    = count_reg;
      case (state_reg)
        ST_WAIT: begin
          if (imem_rvalid) begin
            discard_next = 1'b0;
            state_next   = ST_REQ;
          end else begin
            discard_next = 1'b1;
            state_next   = ST_WAIT;
          end
        end
        ST_REQ: begin
          if (imem_ready) begin
            discard_next = 1'b1;
            state_next   = ST_WAIT;
          end else begin
            discard_next = 1'b0;
            state_next   = ST_REQ;
          end
        end
        default: begin
          discard_next = 1'b0;
          state_next   = ST_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= ST_REQ;
      pc_reg        <= {RESET_PC[XLEN-1:2], 2'b00};
      discard_reg   <= 1'b0;
      buf_pc_reg    <= '0;
      buf_instr_reg <= NOP_INSTR;
      id_valid_reg  <= 1'b0;
      id_pc_reg     <= '0;
      id_instr_reg  <= NOP_INSTR;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      discard_reg   <= discard_next;
      buf_pc_reg    <= buf_pc_next;
      buf_instr_reg <= buf_instr_next;
      id_valid_reg  <= id_valid_next;
      id_pc_reg     <= id_pc_next;
      id_instr_reg  <= id_instr_next;
      count_reg     <= count_next;
    end
  end

endmodule

// File: doc/pipe_fetch_stage.md
Name: pipe_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RV64 core; sits directly upstream of the decode stage.
- Owns the PC register and issues one request at a time to the instruction memory over a ready/valid interface.
- Drives the IF/ID pipeline register and honours stall from the hazard unit and redirect from EX.
- Counts delivered instructions for the bench's pipeline statistics.

Parameters:
XLEN, 64, PC and address width
RESET_PC, 64'h0, PC value loaded at reset
NOP_INSTR, 32'h00000013, instruction driven on id_instr for bubbles/flushes

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-low, clock clk
stall  input  1  hazard unit: hold IF/ID contents, do not advance PC
redirect_valid  input  1  EX: taken branch/jump this cycle
redirect_pc  input  XLEN  EX: target PC; bits [1:0] ignored (treated as 0)
imem_req  output  1  request valid to instruction memory
imem_addr  output  XLEN  request address (always 4-byte aligned)
imem_ready  input  1  memory accepts request when imem_req && imem_ready
imem_rvalid  input  1  response valid (exactly one per accepted request, ≥1 cycle after accept)
imem_rdata  input  32  response instruction
id_valid  output  1  IF/ID holds a real instruction
id_pc  output  XLEN  PC of id_instr
id_instr  output  32  instruction to decode
fetch_count  output  32  instructions delivered to IF/ID, wraps at 2^32

Behaviour:
- Reset (rst==0 at posedge):
  - pc=RESET_PC; state=REQ; discard=0; buffer empty.
  - id_valid=0; id_pc=0; id_instr=NOP_INSTR; fetch_count=0.
  - imem_req=0 during the reset cycle.
  - Reset mid-transaction abandons any outstanding request. The memory model must also be reset.
- States: REQ, WAIT, HOLD.
  - REQ: imem_req=1, imem_addr=pc. On imem_ready, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid:
    - discard=1: drop the data, clear discard, go to REQ.
    - stall=0: load IF/ID with id_valid=1, id_pc=pc, id_instr=imem_rdata; pc+=4; fetch_count+=1; go to REQ.
    - stall=1: capture {pc, rdata} in the 1-entry buffer; go to HOLD.
  - HOLD: imem_req=0. When stall=0: move the buffer to IF/ID (valid=1), pc+=4, fetch_count+=1, go to REQ.
- IF/ID register:
  - stall=1 and no redirect: contents unchanged.
  - stall=0 and nothing delivered this cycle: id_valid=0, id_instr=NOP_INSTR, id_pc unchanged.
- Redirect has top priority, overriding stall:
  - IF/ID flushed: id_valid=0, id_instr=NOP_INSTR.
  - pc=redirect_pc & ~3; HOLD buffer dropped.
  - In WAIT without same-cycle rvalid: discard=1, stay in WAIT.
  - In WAIT with same-cycle rvalid: the response is dropped; go to REQ.
  - In REQ with imem_ready the same cycle: the old-pc request is accepted; go to WAIT with discard=1.
  - Otherwise: go to REQ.
  - The new-target request is issued only after any in-flight response has drained.
- Timing:
  - Latency: request accept at cycle N, rvalid at cycle N+k (k≥1), id_* valid at N+k+1.
  - Peak throughput: 1 instruction per 2 cycles (REQ, then WAIT with k=1).
- Arithmetic:
  - pc increments modulo 2^XLEN; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
  - fetch_count wraps from 32'hFFFFFFFF to 0.
- Memory contract violations (rvalid outside WAIT/discard): response ignored, no state change.
- Redirect and stall asserted together: redirect wins; IF/ID is flushed even though stall=1.

Test Plan:
1. Reset release, RESET_PC=0, memory k=1 returning 0x00100093, 0x00200113, stall=0 → imem_addr 0, 4, 8 on successive REQ cycles. id_instr/id_pc: 0x00100093/0 then 0x00200113/4. fetch_count=2 after 4 cycles of operation.
2. stall=1 held 3 cycles while rvalid arrives for pc=8 → IF/ID keeps pc=4 instr; state HOLD; no new imem_req. On stall release the next cycle shows id_pc=8, valid=1, and fetch_count increments once.
3. redirect_valid with redirect_pc=0x40 during WAIT (k=3) → IF/ID flushed to NOP/valid=0 the next cycle. Stale response for the old pc is dropped. The next imem_addr is 0x40, and id_pc=0x40 is delivered afterwards.
4. redirect_pc=0x43 with stall=1 in HOLD → buffer dropped, id_valid=0, next imem_addr=0x40.
5. imem_ready held low 5 cycles in REQ → imem_req stays 1 with a stable imem_addr; no IF/ID update; fetch_count unchanged.
6. rst driven low mid-WAIT (memory also reset), then released → all outputs at reset values; first request at RESET_PC; no spurious id_valid.
